// File: rtl/seg_hex_scan.sv
// Multiplexed common-anode hex display driver with a tear-free shadow/display buffer.
// Optional leading-zero blanking is enabled by defining SEG_HEX_SCAN_BLANK_LZ_EN.

module seg_hex_scan_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    if (blank) seg = 7'h00;
  end
endmodule

module seg_hex_scan #(
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] in_data,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an_n,
  output logic                pending
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      sh_data_q, sh_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic              pending_q, pending_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]        seg_n_q, seg_n_d;
  logic              dp_n_q, dp_n_d;

  logic                  slot_end, frame_end, blank;
  logic [DIGITS-1:0]     lz_blank;
  logic [DIGITS-1:0][6:0] lane_seg;

`ifdef SEG_HEX_SCAN_BLANK_LZ_EN
  // hi_zero[g]: nibble g and every nibble above it are zero
  logic [DIGITS:0] hi_zero;
  assign hi_zero[DIGITS] = 1'b1;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
`ifdef SEG_HEX_SCAN_BLANK_LZ_EN
    assign hi_zero[g] = hi_zero[g+1] && (disp_data_q[4*g +: 4] == 4'h0);
    if (g == 0) begin : g_d0
      assign lz_blank[g] = 1'b0;
    end else begin : g_dn
      assign lz_blank[g] = hi_zero[g];
    end
`else
    assign lz_blank[g] = 1'b0;
`endif
    seg_hex_scan_lane u_lane (
      .nib   (disp_data_q[4*g +: 4]),
      .blank (lz_blank[g]),
      .seg   (lane_seg[g])
    );
  end

  assign slot_end  = (cnt_q == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
  assign blank     = int'(cnt_q) < BLANK_CYC;

  always_comb begin
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;

    if (slot_end) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    if (load) begin
      sh_data_d = in_data;
      sh_dp_d   = dp_in;
      pending_d = 1'b1;
    end

    // A load landing on the boundary goes straight to the display
    if (frame_end && (pending_q || load)) begin
      disp_data_d = load ? in_data : sh_data_q;
      disp_dp_d   = load ? dp_in   : sh_dp_q;
      pending_d   = 1'b0;
    end
  end

  always_comb begin
    an_n_d  = '1;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (!blank) begin
      for (int i = 0; i < DIGITS; i++) an_n_d[i] = !(idx_q == IW'(i));
      seg_n_d = ~lane_seg[idx_q];
      dp_n_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      an_n_q      <= '1;
      seg_n_q     <= 7'h7F;
      dp_n_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      an_n_q      <= an_n_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign an_n    = an_n_q;
  assign seg_n   = seg_n_q;
  assign dp_n    = dp_n_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_seg_hex_scan.sv
// Randomized and directed bench for seg_hex_scan (DIGITS=2, REFRESH_DIV=4, BLANK_CYC=1).
module tb_seg_hex_scan;
  logic       clk = 1'b0, rst = 1'b0, load = 1'b0, clk_run = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] dp_in = '0;
  logic [6:0] seg_n;
  logic       dp_n, pending;
  logic [1:0] an_n;

  int total = 0, bad = 0;

  seg_hex_scan #(.DIGITS(2), .REFRESH_DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .dp_in(dp_in), .load(load),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .pending(pending)
  );

  always #5 if (clk_run) clk = ~clk;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [1:0] AN_SEQ [8] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};

  // Reference model: time since reset plus the two buffers and the pending flag
  int         m_t;
  logic [7:0] m_sh, m_disp;
  logic [1:0] m_shdp, m_dispdp;
  logic       m_pend;
  logic [10:0] exp_vec;

  function automatic logic [10:0] obs();
    return {an_n, seg_n, dp_n, pending};
  endfunction

  task automatic model_reset();
    m_t = 0; m_sh = '0; m_disp = '0; m_shdp = '0; m_dispdp = '0; m_pend = 1'b0;
  endtask

  task automatic tick(input logic ld, input logic [7:0] d, input logic [1:0] dp);
    int slot, idx, nib, hi;
    logic [1:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, old_pend;
    logic [7:0] old_sh;
    logic [1:0] old_shdp;
    @(negedge clk);
    load = ld; in_data = d; dp_in = dp;
    @(posedge clk);
    slot = m_t % 4;
    idx  = (m_t / 4) % 2;
    nib  = (m_disp >> (4 * idx)) & 15;
    hi   = m_disp >> (4 * idx);
    if (slot < 1) begin
      e_an = 2'b11; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = (idx == 0) ? 2'b10 : 2'b01;
      e_seg = ~GLYPH[nib];
`ifdef SEG_HEX_SCAN_BLANK_LZ_EN
      if (idx > 0 && hi == 0) e_seg = 7'h7F;
`endif
      e_dp = ~m_dispdp[idx];
    end
    old_pend = m_pend; old_sh = m_sh; old_shdp = m_shdp;
    if (ld) begin m_sh = d; m_shdp = dp; m_pend = 1'b1; end
    if ((m_t % 8 == 7) && (old_pend || ld)) begin
      m_disp   = ld ? d  : old_sh;
      m_dispdp = ld ? dp : old_shdp;
      m_pend   = 1'b0;
    end
    m_t++;
    exp_vec = {e_an, e_seg, e_dp, m_pend};
    #1;
  endtask

  task automatic align(input int k);
    while (m_t % 8 != k) tick(1'b0, 8'h00, 2'b00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (an_n !== 2'b11) begin bad++; $display("FAIL reset_an got=%b want=11", an_n); end
    total++; if (seg_n !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h want=7f", seg_n); end
    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp_n); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b want=0", pending); end
    clk_run = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    tick(1'b0, 8'h00, 2'b00);
    total++; if (obs() !== exp_vec) begin bad++; $display("FAIL first_cycle got=%h want=%h", obs(), exp_vec); end
    tick(1'b0, 8'h00, 2'b00);
    total++; if (seg_n !== 7'h40 || an_n !== 2'b10) begin
      bad++; $display("FAIL first_digit got seg=%h an=%b want seg=40 an=10", seg_n, an_n); end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 8'h00, 2'b00);
      total++; if (an_n !== AN_SEQ[(m_t - 1) % 8]) begin
        bad++; $display("FAIL free_run_an t=%0d got=%b want=%b", m_t, an_n, AN_SEQ[(m_t - 1) % 8]); end
      total++; if (obs() !== exp_vec) begin bad++; $display("FAIL free_run t=%0d got=%h want=%h", m_t, obs(), exp_vec); end
    end
  endtask

  task automatic test_load_mid();
    logic [6:0] d0, d1;
    align(2);
    tick(1'b1, 8'hA5, 2'b00);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL load_mid_pend got=%b want=1", pending); end
    while (m_t % 8 != 0) begin
      tick(1'b0, 8'h00, 2'b00);
      total++; if (obs() !== exp_vec) begin bad++; $display("FAIL load_mid_old t=%0d got=%h want=%h", m_t, obs(), exp_vec); end
    end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL load_mid_clear got=%b want=0", pending); end
    d0 = 'x; d1 = 'x;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 2'b00);
      if (an_n == 2'b10) d0 = seg_n;
      if (an_n == 2'b01) d1 = seg_n;
    end
    total++; if (d0 !== 7'h12) begin bad++; $display("FAIL load_mid_d0 got=%h want=12", d0); end
    total++; if (d1 !== 7'h08) begin bad++; $display("FAIL load_mid_d1 got=%h want=08", d1); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] d0, d1;
    logic seen12;
    seen12 = 1'b0;
    align(1);
    tick(1'b1, 8'h12, 2'b00);
    tick(1'b1, 8'h34, 2'b00);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 8'h00, 2'b00);
      if ((an_n == 2'b10 && seg_n == 7'h24) || (an_n == 2'b01 && seg_n == 7'h79)) seen12 = 1'b1;
      if (an_n == 2'b10) d0 = seg_n;
      if (an_n == 2'b01) d1 = seg_n;
      total++; if (obs() !== exp_vec) begin bad++; $display("FAIL b2b t=%0d got=%h want=%h", m_t, obs(), exp_vec); end
    end
    total++; if (seen12 !== 1'b0) begin bad++; $display("FAIL b2b_stale got=%b want=0", seen12); end
    total++; if (d0 !== 7'h19) begin bad++; $display("FAIL b2b_d0 got=%h want=19", d0); end
    total++; if (d1 !== 7'h30) begin bad++; $display("FAIL b2b_d1 got=%h want=30", d1); end
  endtask

  task automatic test_boundary_load();
    logic [6:0] d0, d1;
    logic p0, p1;
    align(7);
    tick(1'b1, 8'h7C, 2'b01);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL bnd_pend got=%b want=0", pending); end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 2'b00);
      if (an_n == 2'b10) begin d0 = seg_n; p0 = dp_n; end
      if (an_n == 2'b01) begin d1 = seg_n; p1 = dp_n; end
    end
    total++; if ({d0, p0} !== {7'h46, 1'b0}) begin bad++; $display("FAIL bnd_d0 got seg=%h dp=%b want seg=46 dp=0", d0, p0); end
    total++; if ({d1, p1} !== {7'h78, 1'b1}) begin bad++; $display("FAIL bnd_d1 got seg=%h dp=%b want seg=78 dp=1", d1, p1); end
  endtask

  task automatic test_leading_zero();
    logic [6:0] d0, d1, want1;
`ifdef SEG_HEX_SCAN_BLANK_LZ_EN
    want1 = 7'h7F;
`else
    want1 = 7'h40;
`endif
    align(3);
    tick(1'b1, 8'h05, 2'b00);
    align(0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 2'b00);
      if (an_n == 2'b10) d0 = seg_n;
      if (an_n == 2'b01) d1 = seg_n;
    end
    total++; if (d0 !== 7'h12) begin bad++; $display("FAIL lz_d0 got=%h want=12", d0); end
    total++; if (d1 !== want1) begin bad++; $display("FAIL lz_d1 got=%h want=%h", d1, want1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) == 0, 8'($urandom), 2'($urandom));
      total++; if (obs() !== exp_vec) begin bad++; $display("FAIL random t=%0d got=%h want=%h", m_t, obs(), exp_vec); end
    end
  endtask

  task automatic test_reset_mid();
    #1 rst = 1'b1;
    #1;
    total++; if (obs() !== {2'b11, 7'h7F, 1'b1, 1'b0}) begin bad++; $display("FAIL mid_reset got=%h want=%h", obs(), {2'b11, 7'h7F, 1'b1, 1'b0}); end
    load = 1'b1; in_data = 8'hFF; dp_in = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    total++; if (obs() !== {2'b11, 7'h7F, 1'b1, 1'b0}) begin bad++; $display("FAIL reset_load got=%h want=%h", obs(), {2'b11, 7'h7F, 1'b1, 1'b0}); end
    rst = 1'b0; load = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 8'hEE, 2'b11);
      total++; if (obs() !== exp_vec) begin bad++; $display("FAIL after_reset t=%0d got=%h want=%h", m_t, obs(), exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_mid();
    test_back_to_back();
    test_boundary_load();
    test_leading_zero();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_hex_scan.md
Name: seg_hex_scan

Overview:
- Downstream display stage for the 8-bit LFSR/shift-register value.
- Takes a DIGITS×4-bit word, holds it in a tear-free double buffer and time-multiplexes it onto a common-anode 7-segment display as hex digits.
- Drives active-low segments and anodes, with a refresh counter and an anti-ghosting blank gap.

Parameters:
- DIGITS, 2, number of hex digits scanned (legal 1..8); data width = 4*DIGITS.
- REFRESH_DIV, 50000, clk cycles per digit slot (legal >= BLANK_CYC+1).
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off (legal 0..REFRESH_DIV-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  4*DIGITS  value to display; nibble i → digit i (digit 0 = least significant).
- dp_in  in  DIGITS  decimal-point request per digit; captured together with in_data.
- load  in  1  capture in_data/dp_in on this rising edge.
- seg_n  out  7  segments a..g on bits 0..6, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  DIGITS  digit anodes, active-low, at most one low.
- pending  out  1  captured value not yet shown.

Behaviour:
- Reset (async, immediate, no clock needed):
  - an_n = all 1s, seg_n = 7'h7F, dp_n = 1, pending = 0.
  - Shadow and display registers = 0; slot counter = 0; digit index = 0.
- Slot counter: counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and the digit index advances by 1, wrapping DIGITS-1 → 0.
- Frame boundary: the cycle where the counter is at REFRESH_DIV-1 and the index is at DIGITS-1.
- Capture:
  - load = 1 → shadow <= {dp_in, in_data}, pending <= 1.
  - Repeated loads before a frame boundary: last one wins.
- Display update, only at a frame boundary and only if pending = 1:
  - display <= shadow, pending <= 0.
  - If load is high in the same cycle, display takes in_data/dp_in directly and pending ends at 0.
  - Result: a frame never mixes old and new digits.
- Outputs are registered; they reflect the counter/index/display state of the previous cycle (1-cycle latency).
- Anode drive:
  - Counter < BLANK_CYC → an_n all 1s, seg_n = 7'h7F, dp_n = 1.
  - Otherwise an_n[index] = 0, all other anodes = 1.
- Segments: seg_n = ~pattern(display nibble[index]); dp_n = ~display_dp[index].
- Pattern hex (g..a), 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- load while in reset is ignored. Reset mid-slot: scan restarts at digit 0, counter 0.
- in_data changes without load have no effect.

Optional Feature:
- Macro: SEG_HEX_SCAN_BLANK_LZ_EN (leading-zero blanking).
- Defined:
  - Digit i > 0 is blanked (seg_n = 7'h7F) when nibble i and all higher nibbles of display are 0.
  - Digit 0 is never blanked.
  - dp_n and an_n are unaffected.
- Undefined: every digit always shows its hex glyph.

Test Plan:
(all scenarios use DIGITS=2, REFRESH_DIV=4, BLANK_CYC=1)
- Assert rst with no clock → an_n=2'b11, seg_n=7'h7F, dp_n=1, pending=0 immediately. Release rst → digit 0 shows 7'h40 ("0") from the second cycle of slot 0.
- Free run after reset → an_n repeats 11,10,10,10,11,01,01,01 with period 8 cycles (output registered one cycle late).
- load=1, in_data=8'hA5, mid-frame → pending=1 until the frame boundary. Then pending=0; digit 0 seg_n=7'h12 ("5"), digit 1 seg_n=7'h08 ("A"); the current frame still shows the old value.
- load 8'h12 then 8'h34 within one frame → only 8'h34 is shown (7'h19 on digit 0, 7'h30 on digit 1); 8'h12 never appears.
- load=1 with in_data=8'h7C and dp_in=2'b01 exactly on the frame-boundary cycle → next frame shows 7C, dp_n=0 on digit 0 only; pending stays 0.
- Display 8'h05 → macro defined: digit 1 seg_n=7'h7F, digit 0 seg_n=7'h12. Macro undefined: digit 1 seg_n=7'h40.
